// File: rtl/seq_det_if.sv
// seq_det_if: requester, detector and frame-report signals of seq_det_arbiter
interface seq_det_if #(parameter int CNT_W = 5);
  logic [1:0] req;
  logic [1:0] din;
  logic [1:0] gnt;
  logic det_rst;
  logic det_in;
  logic det_out;
  logic done;
  logic done_id;
  logic [CNT_W-1:0] match_cnt;
  modport slave (input req, din, det_out, output gnt, det_rst, det_in, done, done_id, match_cnt);
  modport master (output req, din, det_out, input gnt, det_rst, det_in, done, done_id, match_cnt);
endinterface

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin frame sequencer sharing one Moore 101 detector between two serial channels
module seq_det_arbiter #(
  parameter int N_BITS = 16,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  seq_det_if.slave bus
);
  localparam int BW = $clog2(N_BITS);
  typedef enum logic [2:0] {IDLE, ARM, STREAM, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic id, last_id, win, done_id, hit;
  logic [BW-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    win = &bus.req ? ~last_id : bus.req[1];
    state_n = state == IDLE ? (|bus.req ? ARM : IDLE) :
              state == ARM ? STREAM :
              state == STREAM ? (bit_cnt == BW'(N_BITS - 1) ? DRAIN : STREAM) :
              state == DRAIN ? DONE : IDLE;
    bus.gnt = state == STREAM ? (id ? 2'b10 : 2'b01) : 2'b00;
    bus.det_in = state == STREAM && bus.din[id];
    bus.det_rst = rst || state == ARM;
    bus.done = state == DONE;
    // the Moore output lags one bit, so STREAM cycle 0 still reflects the cleared detector
    hit = bus.det_out && (state == DRAIN || (state == STREAM && bit_cnt != '0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id <= 1'b0;
      last_id <= 1'b1;
      done_id <= 1'b0;
      bit_cnt <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |bus.req) id <= win;
      if (state == STREAM) bit_cnt <= bit_cnt + BW'(1);
      if (state == ARM) begin
        cnt <= '0;
        bit_cnt <= '0;
      end else if (hit && cnt != '1) cnt <= cnt + CNT_W'(1);
      if (state == DRAIN) done_id <= id;
      if (state == DONE) last_id <= id;
    end
  end
  assign bus.done_id = done_id;
  assign bus.match_cnt = cnt;
endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin arbiter and frame sequencer that shares one Moore "101" overlapping sequence-detector core between two serial requesters. For each granted frame it clears the detector, streams exactly `N_BITS` bits from the winning channel into it, counts detector hits including the one-cycle Moore output delay, and reports a per-frame match count. It sits between the serial sources and the existing detector core (`clk`/`rst`/`in`/`out`).

## Interface
- `N_BITS`, 16: bits per frame; must be ≥ 3.
- `CNT_W`, 5: width of `match_cnt`; must hold `N_BITS`/2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-channel frame request, level.
- `din`  in  2  per-channel serial data bit.
- `gnt`  out  2  one-hot; high for the granted channel during STREAM only.
- `det_rst`  out  1  to detector `rst`.
- `det_in`  out  1  to detector `in`.
- `det_out`  in  1  from detector `out`, Moore output.
- `done`  out  1  one-cycle frame-complete pulse.
- `done_id`  out  1  channel of the completed frame.
- `match_cnt`  out  CNT_W  number of hits in the last frame.

## Operation
- States: IDLE, ARM, STREAM, DRAIN, DONE.
- **IDLE**
  - `gnt=0`, `det_in=0`.
  - If any `req` is high: latch the winner into `id`, go to ARM.
  - Only one request high: that channel wins.
  - Both high: the channel ≠ `last_id` wins.
- **ARM** (1 cycle)
  - `det_rst=1`, which clears the detector to its S0 state.
  - `match_cnt` cleared to 0; `bit_cnt` cleared to 0.
  - Go to STREAM.
- **STREAM** (exactly `N_BITS` cycles)
  - `gnt[id]=1`; `det_in = din[id]`, combinational.
  - The detector samples one bit per edge; `bit_cnt` increments each cycle.
  - When `bit_cnt ≥ 1` and `det_out=1`: `match_cnt` increments.
  - At `bit_cnt == N_BITS-1`: go to DRAIN.
- **DRAIN** (1 cycle)
  - `gnt=0`, `det_in=0`.
  - If `det_out=1`: `match_cnt` increments. This captures a hit on the final bit.
  - Go to DONE.
- **DONE** (1 cycle)
  - `done=1`, `done_id=id`, `last_id ← id`.
  - Go to IDLE.
- **Outputs outside the frame**
  - `match_cnt` and `done_id` hold their values until the next ARM.
- **Counter rules**
  - `match_cnt` saturates at `2^CNT_W-1`; it never wraps.
  - A frame samples exactly `N_BITS` detector outputs: STREAM cycles 1..N_BITS-1 plus DRAIN.
- **Request drop mid-frame**
  - A `req` deasserted after grant is ignored; the frame completes, `din` is still sampled, and `done` still pulses.
- **Requester obligations**
  - The requester presents bit k on `din` during STREAM cycle k, i.e. the k-th cycle with `gnt` high.
  - It may hold `req` high for back-to-back frames.
- **Reset behaviour**
  - `det_rst = rst | (state==ARM)`, so the detector is also cleared by system reset.
  - Reset, at any time including mid-frame: next state IDLE; `gnt=0`, `done=0`, `done_id=0`, `match_cnt=0`, `det_in=0`; `last_id=1`, so channel 0 wins the first tie.
  - An aborted frame never produces `done`.

## Timing
- `req` seen high in IDLE at edge t: ARM during cycle t+1, `gnt` high from cycle t+2 for `N_BITS` cycles.
- After `gnt` drops: DRAIN, then DONE.
- Frame length: `N_BITS+3` cycles, from ARM through DONE.
- Minimum frame-to-frame period with `req` held: `N_BITS+4` cycles, including the IDLE cycle.
- `done` is high exactly 1 cycle, 2 cycles after the last `gnt` cycle.
- `match_cnt` is valid in the `done` cycle and stable after it.
- `gnt` is always one-hot or zero; it is never high in ARM, DRAIN, DONE or IDLE.
- Detector contract: Moore core with synchronous reset. A hit on the bit sampled at edge e appears on `det_out` in the cycle after e.

## Test plan
All scenarios run with `N_BITS=8` against the team's Moore 101 overlapping detector core.

- **Single channel, overlapping hits:** ch0 only; stream `1,0,1,0,1,0,0,0` → `done` with `done_id=0`, `match_cnt=2`; `gnt[0]` high for exactly 8 cycles.
- **Final-bit hit:** ch1 only; stream `1,0,1,1,0,1,0,1` → `match_cnt=3`. The third hit is counted in DRAIN.
- **Tie after reset:** both `req` high → ch0 frame first, then ch1. Alternate thereafter while both are held; `done_id` sequence 0,1,0,1; period 12 cycles.
- **No-match patterns:** stream `1,1,1,1,1,1,1,1` → `match_cnt=0`; stream `0,0,0,0,0,0,0,0` → `match_cnt=0`.
- **Reset mid-STREAM:** assert `rst` during STREAM cycle 4 → next cycle `gnt=0`, `det_rst=1`, `match_cnt=0`, state IDLE, no `done` pulse. With `req[1]` held the next grant goes to ch1; with both held it goes to ch0.
- **Request dropped mid-frame:** ch0 drops `req` during STREAM cycle 2 while streaming `1,0,1,0,1,0,1,0` → frame completes, `match_cnt=3`, `done` pulses.
